mole_round_ctrl: RTL and testbench
==================================

// Module: mole_round_ctrl
// PURPOSE
//  Game-round sequencer for whack-a-mole. Draws a mole position from the 3-bit random source,
//  lights that LED for a timed window, judges debounced button presses, and keeps score/misses
//  over a fixed number of rounds. Sits between the random generator, button debouncers and LED/score display.
// PARAMETERS
//  ROUNDS       16   moles per game (1..255)
//  SHOW_TICKS   750  ticks a mole stays lit (1..2^CW-1)
//  GAP_TICKS    250  dark ticks between moles (1..2^CW-1)
//  FLASH_TICKS  100  ticks hit_flash stays high after a hit (1..2^CW-1)
//  CW           16   width of the tick down-counter
// PORTS
//  clk        in   1  system clock; all state on rising edge
//  rst_n      in   1  asynchronous, active-low reset
//  start      in   1  1-cycle pulse: begin a game (ignored while busy)
//  tick       in   1  1-cycle timebase enable (e.g. 1 ms); all durations count ticks
//  rand_idx   in   3  current random mole position 0..7
//  rand_next  out  1  1-cycle pulse: advance random generator
//  btn_pulse  in   8  debounced 1-cycle press pulses, bit i = button under LED i
//  led        out  8  one-hot mole display, 0 when no mole shown
//  hit_flash  out  1  high during hit feedback window
//  score      out  8  hits this game, saturates at 255
//  misses     out  8  timeouts + wrong presses this game, saturates at 255
//  busy       out  1  game in progress (state not IDLE/DONE)
//  done       out  1  high in DONE until next start
// BEHAVIOUR
//  Reset: state=IDLE; led=0, hit_flash=0, rand_next=0, score=0, misses=0, busy=0, done=0, counters=0.
//  All outputs registered. Reset mid-game aborts immediately to IDLE; no partial state retained.
//  States: IDLE, SPAWN, SHOW, HIT, GAP, DONE.
//  IDLE/DONE: led=0. start=1 -> clear score, misses, round count; done<=0; -> SPAWN.
//  SPAWN (exactly 1 cycle): mole_idx<=rand_idx; rand_next=1 this cycle; cnt<=SHOW_TICKS; -> SHOW.
//   start sampled at edge N: SPAWN during N..N+1, led one-hot valid from edge N+2.
//  SHOW: led=1<<mole_idx. cnt decrements on tick. Per cycle, priority:
//   1) btn_pulse[mole_idx]=1 -> score+1 (sat), cnt<=FLASH_TICKS, -> HIT; other bits same cycle ignored.
//   2) else any btn_pulse bit=1 -> misses+1 (sat), once per cycle regardless of bit count; stay SHOW.
//   3) tick with cnt==1 -> misses+1 (sat), cnt<=GAP_TICKS, -> GAP (timeout).
//   Correct press in same cycle as final tick counts as hit (rule 1 wins), no miss.
//   Wrong press in same cycle as final tick: one miss for press + one for timeout (+2, sat).
//  HIT: led=0, hit_flash=1; cnt decrements on tick; tick at cnt==1 -> cnt<=GAP_TICKS, -> GAP.
//  GAP: led=0; tick at cnt==1 -> round+1; round==ROUNDS -> DONE, else -> SPAWN.
//  Buttons ignored outside SHOW. start ignored in SPAWN/SHOW/HIT/GAP.
//  busy=1 in SPAWN/SHOW/HIT/GAP. done=1 only in DONE. score/misses hold in DONE until next start.
//  Duration: SHOW timeout exactly SHOW_TICKS ticks after entering SHOW; tick in SPAWN cycle not counted.
//  Counters never wrap: score/misses saturate; cnt reloaded before reaching 0.
// TESTING
//  1 Reset mid-SHOW (rst_n low 1 cycle) -> all outputs 0, state IDLE, next start begins fresh game.
//  2 ROUNDS=2,SHOW=3,GAP=2: start, rand_idx=5, no presses -> led=8'h20 for 3 ticks, misses=2, done=1, score=0.
//  3 rand_idx=3, btn_pulse=8'h08 on 2nd tick of SHOW -> score=1, hit_flash high FLASH_TICKS ticks, led=0.
//  4 rand_idx=3, btn_pulse=8'h81 in SHOW -> misses+1 only, mole stays lit; then 8'h08 -> score+1.
//  5 Final SHOW tick coincident with btn_pulse=8'h08 -> hit (score+1, misses unchanged).
//  6 start pulse while busy -> ignored; score/misses 255 with further hits/misses -> stay 255; rand_next 1 pulse per SPAWN.

Source files
------------

// File: rtl/mole_round_ctrl.sv
// Whack-a-mole round sequencer: spawns a mole from the random source, times the lit window,
// judges button presses and accumulates saturating score/miss counts over a fixed number of rounds.
module mole_round_ctrl #(
  parameter int ROUNDS      = 16,
  parameter int SHOW_TICKS  = 750,
  parameter int GAP_TICKS   = 250,
  parameter int FLASH_TICKS = 100,
  parameter int CW          = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       tick,
  input  logic [2:0] rand_idx,
  output logic       rand_next,
  input  logic [7:0] btn_pulse,
  output logic [7:0] led,
  output logic       hit_flash,
  output logic [7:0] score,
  output logic [7:0] misses,
  output logic       busy,
  output logic       done
);

  // state   | meaning
  // IDLE    | after reset, waiting for start
  // SPAWN   | one cycle: latch mole position, advance random source
  // SHOW    | mole lit, judging presses, counting down SHOW_TICKS
  // HIT     | hit feedback flash for FLASH_TICKS
  // GAP     | dark pause between moles for GAP_TICKS
  // DONE    | game over, results held until next start
  typedef enum logic [2:0] {S_IDLE, S_SPAWN, S_SHOW, S_HIT, S_GAP, S_DONE} state_t;

  localparam logic [CW-1:0] SHOW_C   = CW'(SHOW_TICKS);
  localparam logic [CW-1:0] GAP_C    = CW'(GAP_TICKS);
  localparam logic [CW-1:0] FLASH_C  = CW'(FLASH_TICKS);
  localparam logic [CW-1:0] ONE_C    = CW'(1);
  localparam logic [7:0]    ROUNDS_C = 8'(ROUNDS);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    mole_idx_q, mole_idx_d;
  logic [7:0]    round_q, round_d;
  logic [7:0]    score_q, score_d;
  logic [7:0]    misses_q, misses_d;
  logic [7:0]    led_q, led_d;
  logic          hit_flash_q, hit_flash_d;
  logic          rand_next_q, rand_next_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [1:0]    miss_inc;

  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] b);
    logic [8:0] sum;
    sum = {1'b0, a} + {7'b0, b};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mole_idx_d = mole_idx_q;
    round_d    = round_q;
    score_d    = score_q;
    misses_d   = misses_q;
    miss_inc   = 2'd0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          score_d  = 8'd0;
          misses_d = 8'd0;
          round_d  = 8'd0;
          state_d  = S_SPAWN;
        end
      end
      S_SPAWN: begin
        mole_idx_d = rand_idx;
        cnt_d      = SHOW_C;
        state_d    = S_SHOW;
      end
      S_SHOW: begin
        if (btn_pulse[mole_idx_q]) begin
          score_d = sat_add8(score_q, 2'd1);
          cnt_d   = FLASH_C;
          state_d = S_HIT;
        end else begin
          // a wrong press and the timeout in the same cycle each cost a miss
          if (|btn_pulse) miss_inc = miss_inc + 2'd1;
          if (tick) begin
            if (cnt_q == ONE_C) begin
              miss_inc = miss_inc + 2'd1;
              cnt_d    = GAP_C;
              state_d  = S_GAP;
            end else begin
              cnt_d = cnt_q - ONE_C;
            end
          end
          misses_d = sat_add8(misses_q, miss_inc);
        end
      end
      S_HIT: begin
        if (tick) begin
          if (cnt_q == ONE_C) begin
            cnt_d   = GAP_C;
            state_d = S_GAP;
          end else begin
            cnt_d = cnt_q - ONE_C;
          end
        end
      end
      S_GAP: begin
        if (tick) begin
          if (cnt_q == ONE_C) begin
            round_d = round_q + 8'd1;
            state_d = (round_q + 8'd1 == ROUNDS_C) ? S_DONE : S_SPAWN;
          end else begin
            cnt_d = cnt_q - ONE_C;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // led/hit_flash follow the registered state, so the mole lights two edges after start
  always_comb begin
    led_d       = (state_q == S_SHOW) ? (8'd1 << mole_idx_q) : 8'd0;
    hit_flash_d = (state_q == S_HIT);
    rand_next_d = (state_d == S_SPAWN);
    busy_d      = (state_d == S_SPAWN) || (state_d == S_SHOW) ||
                  (state_d == S_HIT)   || (state_d == S_GAP);
    done_d      = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      mole_idx_q  <= 3'd0;
      round_q     <= 8'd0;
      score_q     <= 8'd0;
      misses_q    <= 8'd0;
      led_q       <= 8'd0;
      hit_flash_q <= 1'b0;
      rand_next_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mole_idx_q  <= mole_idx_d;
      round_q     <= round_d;
      score_q     <= score_d;
      misses_q    <= misses_d;
      led_q       <= led_d;
      hit_flash_q <= hit_flash_d;
      rand_next_q <= rand_next_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign led       = led_q;
  assign hit_flash = hit_flash_q;
  assign rand_next = rand_next_q;
  assign score     = score_q;
  assign misses    = misses_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_mole_round_ctrl.sv
// Bench for mole_round_ctrl: table of rounds played as 2-round games, plus hand sequences
// for start-while-busy, miss saturation and reset in the middle of a game.
module tb_mole_round_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       tick;
  logic [2:0] rand_idx;
  logic       rand_next;
  logic [7:0] btn_pulse;
  logic [7:0] led;
  logic       hit_flash;
  logic [7:0] score;
  logic [7:0] misses;
  logic       busy;
  logic       done;

  mole_round_ctrl #(
    .ROUNDS(2), .SHOW_TICKS(3), .GAP_TICKS(2), .FLASH_TICKS(2), .CW(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .tick(tick), .rand_idx(rand_idx),
    .rand_next(rand_next), .btn_pulse(btn_pulse), .led(led), .hit_flash(hit_flash),
    .score(score), .misses(misses), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [7:0] exp;
  } exp_t;

  typedef struct {
    logic [2:0] idx;
    logic [7:0] pre_btn;
    int         at;
    logic [7:0] val;
    bit         hit;
    logic [7:0] e_score;
    logic [7:0] e_miss;
  } round_t;

  exp_t   sb_q[$];
  round_t tbl[6];
  int     n_tests = 0;
  int     n_fail  = 0;

  task automatic push(input string n, input logic [7:0] e);
    exp_t x;
    x.name = n;
    x.exp  = e;
    sb_q.push_back(x);
  endtask

  task automatic pop_check(input logic [7:0] act);
    exp_t x;
    n_tests++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL sb_empty: got %0h with nothing expected", act);
    end else begin
      x = sb_q.pop_front();
      if (act !== x.exp) begin
        n_fail++;
        $display("FAIL %s: got %0h expected %0h", x.name, act, x.exp);
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    tick      = 1'b0;
    btn_pulse = 8'h00;
    start     = 1'b0;
  endtask

  task automatic tick_cyc(input logic [7:0] b);
    tick      = 1'b1;
    btn_pulse = b;
    cyc();
  endtask

  // Entered with the DUT in SPAWN; leaves it in SPAWN (next round) or DONE.
  task automatic run_round(input round_t r);
    logic [7:0] mole;
    mole     = 8'(8'd1 << r.idx);
    rand_idx = r.idx;
    push("rand_next_spawn", 8'd1); pop_check({7'b0, rand_next});
    push("busy_spawn", 8'd1);      pop_check({7'b0, busy});
    cyc();
    push("rand_next_show", 8'd0);  pop_check({7'b0, rand_next});
    push("led_first_show", 8'd0);  pop_check(led);
    cyc();
    push("led_lit", mole);         pop_check(led);
    if (r.pre_btn != 8'h00) begin
      btn_pulse = r.pre_btn;
      cyc();
      push("led_after_wrong", mole); pop_check(led);
    end
    for (int k = 1; k <= 3; k++) begin
      tick_cyc((k == r.at) ? r.val : 8'h00);
      if (r.hit && k == r.at) break;
    end
    cyc();
    push("led_off", 8'd0);              pop_check(led);
    push("hit_flash", {7'b0, r.hit});   pop_check({7'b0, hit_flash});
    push("score_round", r.e_score);     pop_check(score);
    push("misses_round", r.e_miss);     pop_check(misses);
    if (r.hit) begin
      tick_cyc(8'h00);
      push("flash_held", 8'd1);         pop_check({7'b0, hit_flash});
      tick_cyc(8'h00);
      cyc();
      push("flash_end", 8'd0);          pop_check({7'b0, hit_flash});
    end
    tick_cyc(8'h00);
    tick_cyc(8'h00);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, expected %0d tests", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    //        idx   pre     at val    hit sc miss
    tbl[0] = '{3'd5, 8'h00, 0, 8'h00, 0, 8'd0, 8'd1};
    tbl[1] = '{3'd5, 8'h00, 0, 8'h00, 0, 8'd0, 8'd2};
    tbl[2] = '{3'd3, 8'h81, 2, 8'h08, 1, 8'd1, 8'd1};
    tbl[3] = '{3'd3, 8'h00, 3, 8'h08, 1, 8'd2, 8'd1};
    tbl[4] = '{3'd0, 8'h00, 3, 8'h02, 0, 8'd0, 8'd2};
    tbl[5] = '{3'd7, 8'h7F, 1, 8'h80, 1, 8'd1, 8'd3};

    rst_n = 1'b0; start = 1'b0; tick = 1'b0; btn_pulse = 8'h00; rand_idx = 3'd0;
    #3;
    push("rst_led", 8'd0);    pop_check(led);
    push("rst_score", 8'd0);  pop_check(score);
    push("rst_misses", 8'd0); pop_check(misses);
    push("rst_ctrl", 8'd0);   pop_check({4'b0, hit_flash, rand_next, busy, done});
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();

    for (int g = 0; g < 3; g++) begin
      start = 1'b1;
      cyc();
      for (int r = 0; r < 2; r++) run_round(tbl[2*g + r]);
      push("game_done", 8'd1);              pop_check({7'b0, done});
      push("game_busy", 8'd0);              pop_check({7'b0, busy});
      push("game_score", tbl[2*g+1].e_score); pop_check(score);
      push("game_misses", tbl[2*g+1].e_miss); pop_check(misses);
      cyc();
      push("done_held", 8'd1);              pop_check({7'b0, done});
    end

    // start while busy, then push misses into saturation
    start = 1'b1;
    cyc();
    push("restart_clears_done", 8'd0); pop_check({7'b0, done});
    push("restart_score", 8'd0);       pop_check(score);
    rand_idx = 3'd2;
    cyc(); cyc();
    push("sat_led", 8'h04); pop_check(led);
    start = 1'b1;
    cyc(); cyc();
    push("busy_start_led", 8'h04);  pop_check(led);
    push("busy_start_rn", 8'd0);    pop_check({7'b0, rand_next});
    push("busy_start_busy", 8'd1);  pop_check({7'b0, busy});
    for (int i = 0; i < 260; i++) begin
      btn_pulse = 8'h01;
      cyc();
    end
    push("misses_sat", 8'hFF);   pop_check(misses);
    push("sat_led_held", 8'h04); pop_check(led);
    tick_cyc(8'h00);
    tick_cyc(8'h00);
    tick_cyc(8'h01);
    cyc();
    push("misses_sat_timeout", 8'hFF); pop_check(misses);
    push("sat_led_off", 8'd0);         pop_check(led);
    tick_cyc(8'h00);
    tick_cyc(8'h00);
    push("round2_rand_next", 8'd1); pop_check({7'b0, rand_next});
    cyc(); cyc();
    push("round2_led", 8'h04); pop_check(led);

    // asynchronous reset in the middle of SHOW
    rst_n = 1'b0;
    #1;
    push("midrst_led", 8'd0);    pop_check(led);
    push("midrst_misses", 8'd0); pop_check(misses);
    push("midrst_ctrl", 8'd0);   pop_check({4'b0, hit_flash, rand_next, busy, done});
    cyc();
    rst_n = 1'b1;
    cyc();
    push("post_rst_busy", 8'd0); pop_check({7'b0, busy});
    push("post_rst_led", 8'd0);  pop_check(led);
    start = 1'b1;
    cyc();
    push("fresh_rand_next", 8'd1); pop_check({7'b0, rand_next});
    push("fresh_busy", 8'd1);      pop_check({7'b0, busy});
    push("fresh_misses", 8'd0);    pop_check(misses);
    push("fresh_score", 8'd0);     pop_check(score);

    if (sb_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL sb_leftover: got %0d pending expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
